// File: rtl/mem_sched_pkg.sv
// Shared types, default sizes and index helpers for the multi-port memory scheduler.
package mem_sched_pkg;

  typedef enum logic {INIT, RUN} state_e;

  localparam int unsigned DefNumReq  = 8;
  localparam int unsigned DefBitReq  = 3;
  localparam int unsigned DefNumWprt = 4;
  localparam int unsigned DefNumRprt = 4;
  localparam int unsigned DefBitAddr = 6;
  localparam int unsigned DefNumAddr = 64;
  localparam int unsigned DefWidth   = 24;

  function automatic int unsigned rot_idx(int unsigned base, int unsigned off, int unsigned n);
    return (base + off) % n;
  endfunction

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough to hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_port_sched_if.sv
// Requester-side bus of the scheduler: requests, same-cycle grants and registered read responses.
interface mem_port_sched_if
  import mem_sched_pkg::*;
#(
  parameter int unsigned NUMREQ  = DefNumReq,
  parameter int unsigned BITADDR = DefBitAddr,
  parameter int unsigned WIDTH   = DefWidth
);
  logic [NUMREQ-1:0]  req_write;
  logic [NUMREQ-1:0]  req_read;
  logic [BITADDR-1:0] req_wadr [NUMREQ];
  logic [BITADDR-1:0] req_radr [NUMREQ];
  logic [WIDTH-1:0]   req_din  [NUMREQ];
  logic [NUMREQ-1:0]  req_wgnt;
  logic [NUMREQ-1:0]  req_rgnt;
  logic [NUMREQ-1:0]  rsp_vld;
  logic [WIDTH-1:0]   rsp_dout [NUMREQ];

  modport master (
    output req_write, req_read, req_wadr, req_radr, req_din,
    input  req_wgnt, req_rgnt, rsp_vld, rsp_dout
  );

  modport slave (
    input  req_write, req_read, req_wadr, req_radr, req_din,
    output req_wgnt, req_rgnt, rsp_vld, rsp_dout
  );
endinterface

// File: rtl/mem_sched_rr.sv
// Round-robin multi-grant picker: grants up to max_gnt unblocked requests scanning from ptr.
module mem_sched_rr
  import mem_sched_pkg::*;
#(
  parameter int unsigned NUMREQ = DefNumReq,
  parameter int unsigned BITREQ = DefBitReq,
  parameter int unsigned NUMPRT = DefNumWprt,
  parameter int unsigned CNTW   = cnt_width(NUMPRT)
) (
  input  logic [NUMREQ-1:0] req,
  input  logic [BITREQ-1:0] ptr,
  input  logic [CNTW-1:0]   max_gnt,
  input  logic [NUMREQ-1:0] block,
  output logic [NUMREQ-1:0] gnt,
  output logic [NUMPRT-1:0] port_vld,
  output logic [BITREQ-1:0] port_idx [NUMPRT],
  output logic [BITREQ-1:0] next_ptr
);
  localparam int unsigned PIW = idx_width(NUMPRT);

  always_comb begin
    logic [CNTW-1:0]   cnt;
    logic [BITREQ-1:0] idx;
    gnt      = '0;
    port_vld = '0;
    for (int unsigned p = 0; p < NUMPRT; p++) port_idx[p] = '0;
    next_ptr = ptr;
    cnt      = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NUMREQ; k++) begin
      idx = BITREQ'(rot_idx(32'(ptr), k, NUMREQ));
      if (req[idx] && !block[idx] && (cnt < max_gnt)) begin
        gnt[idx]                = 1'b1;
        port_vld[cnt[PIW-1:0]]  = 1'b1;
        port_idx[cnt[PIW-1:0]]  = idx;
        cnt                     = cnt + CNTW'(1);
        next_ptr                = BITREQ'(rot_idx(32'(idx), 1, NUMREQ));
      end
    end
  end

endmodule

// File: rtl/mem_port_sched.sv
// Maps requester reads/writes onto memory ports round-robin; zero-fills the memory after reset.
module mem_port_sched
  import mem_sched_pkg::*;
#(
  parameter int unsigned NUMREQ  = DefNumReq,
  parameter int unsigned BITREQ  = DefBitReq,
  parameter int unsigned NUMWPRT = DefNumWprt,
  parameter int unsigned NUMRPRT = DefNumRprt,
  parameter int unsigned BITADDR = DefBitAddr,
  parameter int unsigned NUMADDR = DefNumAddr,
  parameter int unsigned WIDTH   = DefWidth
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_sched_if.slave     bus,
  output logic                init_done,
  output logic [NUMWPRT-1:0]  write,
  output logic [BITADDR-1:0]  wr_adr  [NUMWPRT],
  output logic [WIDTH-1:0]    din     [NUMWPRT],
  output logic [NUMRPRT-1:0]  read,
  output logic [BITADDR-1:0]  rd_adr  [NUMRPRT],
  input  logic [WIDTH-1:0]    rd_dout [NUMRPRT]
);
  localparam int unsigned WCNTW = cnt_width(NUMWPRT);
  localparam int unsigned RCNTW = cnt_width(NUMRPRT);

  state_e             state_q;
  logic [BITADDR-1:0] init_adr_q;
  logic               init_done_q;
  logic [BITREQ-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUMREQ-1:0]  rsp_vld_q;
  logic [WIDTH-1:0]   rsp_dout_q [NUMREQ];
  logic [WIDTH-1:0]   rsp_dout_d [NUMREQ];

  logic               run;
  logic [NUMREQ-1:0]  wreq, rreq, wblock, wgnt, rgnt;
  logic [NUMWPRT-1:0] wport_vld;
  logic [BITREQ-1:0]  wport_idx [NUMWPRT];
  logic [NUMRPRT-1:0] rport_vld;
  logic [BITREQ-1:0]  rport_idx [NUMRPRT];

  assign run  = (state_q == RUN) && !rst;
  assign wreq = bus.req_write & {NUMREQ{run}};
  assign rreq = bus.req_read & {NUMREQ{run}};

  // Only the first writer of an address in scan order can win; later ones wait a cycle.
  always_comb begin
    logic [BITREQ-1:0] ia, ib;
    wblock = '0;
    ia     = '0;
    ib     = '0;
    for (int unsigned a = 0; a < NUMREQ; a++) begin
      for (int unsigned b = a + 1; b < NUMREQ; b++) begin
        ia = BITREQ'(rot_idx(32'(wr_ptr_q), a, NUMREQ));
        ib = BITREQ'(rot_idx(32'(wr_ptr_q), b, NUMREQ));
        if (wreq[ia] && (bus.req_wadr[ia] == bus.req_wadr[ib])) wblock[ib] = 1'b1;
      end
    end
  end

  mem_sched_rr #(.NUMREQ(NUMREQ), .BITREQ(BITREQ), .NUMPRT(NUMWPRT)) u_wr_rr (
    .req      (wreq),
    .ptr      (wr_ptr_q),
    .max_gnt  (WCNTW'(NUMWPRT)),
    .block    (wblock),
    .gnt      (wgnt),
    .port_vld (wport_vld),
    .port_idx (wport_idx),
    .next_ptr (wr_ptr_d)
  );

  mem_sched_rr #(.NUMREQ(NUMREQ), .BITREQ(BITREQ), .NUMPRT(NUMRPRT)) u_rd_rr (
    .req      (rreq),
    .ptr      (rd_ptr_q),
    .max_gnt  (RCNTW'(NUMRPRT)),
    .block    ('0),
    .gnt      (rgnt),
    .port_vld (rport_vld),
    .port_idx (rport_idx),
    .next_ptr (rd_ptr_d)
  );

  always_comb begin
    for (int unsigned p = 0; p < NUMWPRT; p++) begin
      write[p]  = 1'b0;
      wr_adr[p] = '0;
      din[p]    = '0;
      if (!rst && (state_q == INIT)) begin
        write[p]  = 1'b1;
        wr_adr[p] = init_adr_q + BITADDR'(p);
      end else if (wport_vld[p]) begin
        write[p]  = 1'b1;
        wr_adr[p] = bus.req_wadr[wport_idx[p]];
        din[p]    = bus.req_din[wport_idx[p]];
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUMRPRT; p++) begin
      read[p]   = rport_vld[p];
      rd_adr[p] = rport_vld[p] ? bus.req_radr[rport_idx[p]] : '0;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NUMREQ; r++) rsp_dout_d[r] = '0;
    for (int unsigned p = 0; p < NUMRPRT; p++) begin
      if (rport_vld[p]) rsp_dout_d[rport_idx[p]] = rd_dout[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_adr_q  <= '0;
      init_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_vld_q   <= '0;
      for (int unsigned r = 0; r < NUMREQ; r++) rsp_dout_q[r] <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          init_adr_q <= init_adr_q + BITADDR'(NUMWPRT);
          if (init_adr_q == BITADDR'(NUMADDR - NUMWPRT)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
        end
      endcase
      rsp_vld_q <= rgnt;
      for (int unsigned r = 0; r < NUMREQ; r++) rsp_dout_q[r] <= rsp_dout_d[r];
    end
  end

  assign bus.req_wgnt = wgnt;
  assign bus.req_rgnt = rgnt;
  assign bus.rsp_vld  = rsp_vld_q;
  assign bus.rsp_dout = rsp_dout_q;
  assign init_done    = init_done_q;

endmodule
